// File: rtl/alarma_tono_if.sv
// ---------------------------------------------------------------------------
// alarma_tono_if
// Groups the alarm-side signals of the tone sequencer into one bundle.
//   bit_alarma : alarm match level from the data block (driven by master)
//   silenciar  : one-cycle silence request from the keyboard path (master)
//   ampPWM     : audio amplifier drive (driven by slave)
//   sonando    : high while a beep pattern is in progress (slave)
//   estado     : 2-bit state code, 00 IDLE / 01 ON / 10 OFF / 11 DONE (slave)
// The master modport is the side that feeds the sequencer, and the slave
// modport is the sequencer itself.
// ---------------------------------------------------------------------------
interface alarma_tono_if;
    logic       bit_alarma;
    logic       silenciar;
    logic       ampPWM;
    logic       sonando;
    logic [1:0] estado;

    modport master (
        output bit_alarma,
        output silenciar,
        input  ampPWM,
        input  sonando,
        input  estado
    );

    modport slave (
        input  bit_alarma,
        input  silenciar,
        output ampPWM,
        output sonando,
        output estado
    );
endinterface

// File: rtl/alarma_tono.sv
// ---------------------------------------------------------------------------
// alarma_tono
// Alarm sound sequencer. A rising edge on bit_alarma starts a burst pattern:
// a square-wave tone for BEEP_ON cycles, followed by silence for BEEP_OFF
// cycles. This pattern repeats MAX_BEEPS times, or forever if MAX_BEEPS is 0.
// The burst stops early when the alarm level drops or when silence is
// requested.
// Ports:
//   reloj  : system clock, all logic on the rising edge
//   resetM : synchronous, active-high reset
//   bus    : alarma_tono_if.slave (bit_alarma, silenciar in;
//            ampPWM, sonando, estado out)
// ---------------------------------------------------------------------------
module alarma_tono #(
    parameter int TONE_HALF = 25000,
    parameter int BEEP_ON   = 25000000,
    parameter int BEEP_OFF  = 25000000,
    parameter int MAX_BEEPS = 30,
    parameter int CNT_W     = 25
) (
    input  logic          reloj,
    input  logic          resetM,
    alarma_tono_if.slave  bus
);

    // The encoding matches the estado output code, so the state register
    // can be driven straight onto the port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_HALF - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(BEEP_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(BEEP_OFF - 1);
    localparam logic [7:0]       BEEP_MAX  = 8'(MAX_BEEPS);

    state_t           state_q, state_d;
    logic             amp_q, amp_d;
    logic             alarma_q, alarma_d;
    logic [CNT_W-1:0] cnt_tono_q, cnt_tono_d;
    logic [CNT_W-1:0] cnt_fase_q, cnt_fase_d;
    logic [7:0]       beeps_q, beeps_d;

    logic             rise;
    logic [7:0]       beeps_inc;

    assign rise = bus.bit_alarma & ~alarma_q;

    // The beep count stops at 255 so that an unlimited alarm never wraps.
    assign beeps_inc = (beeps_q == 8'hFF) ? 8'hFF : beeps_q + 8'd1;

    // State register. Reset also clears the alarm history, so an alarm level
    // that is still high is seen as a fresh rise right after reset releases.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_q    <= ST_IDLE;
            amp_q      <= 1'b0;
            alarma_q   <= 1'b0;
            cnt_tono_q <= '0;
            cnt_fase_q <= '0;
            beeps_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            amp_q      <= amp_d;
            alarma_q   <= alarma_d;
            cnt_tono_q <= cnt_tono_d;
            cnt_fase_q <= cnt_fase_d;
            beeps_q    <= beeps_d;
        end
    end

    // Next-state logic. An alarm level drop has priority over a silence
    // request, and both have priority over the normal beep sequencing.
    // A silence request counts only when a burst is running or is starting
    // in this same cycle, so a request arriving in IDLE is ignored.
    always_comb begin
        state_d    = state_q;
        amp_d      = amp_q;
        alarma_d   = bus.bit_alarma;
        cnt_tono_d = cnt_tono_q;
        cnt_fase_d = cnt_fase_q;
        beeps_d    = beeps_q;

        if (!bus.bit_alarma) begin
            state_d    = ST_IDLE;
            amp_d      = 1'b0;
            cnt_tono_d = '0;
            cnt_fase_d = '0;
        end else if (bus.silenciar && (state_q != ST_IDLE || rise)) begin
            state_d    = ST_DONE;
            amp_d      = 1'b0;
            cnt_tono_d = '0;
            cnt_fase_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d    = ST_ON;
                        amp_d      = 1'b1;
                        cnt_tono_d = '0;
                        cnt_fase_d = '0;
                        beeps_d    = 8'd0;
                    end
                end
                ST_ON: begin
                    // End of beep wins over a tone toggle in the same cycle.
                    if (cnt_fase_q == ON_LAST) begin
                        beeps_d    = beeps_inc;
                        amp_d      = 1'b0;
                        cnt_tono_d = '0;
                        cnt_fase_d = '0;
                        if (MAX_BEEPS != 0 && beeps_inc == BEEP_MAX) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_OFF;
                        end
                    end else begin
                        cnt_fase_d = cnt_fase_q + 1'b1;
                        if (cnt_tono_q == TONE_LAST) begin
                            amp_d      = ~amp_q;
                            cnt_tono_d = '0;
                        end else begin
                            cnt_tono_d = cnt_tono_q + 1'b1;
                        end
                    end
                end
                ST_OFF: begin
                    amp_d = 1'b0;
                    if (cnt_fase_q == OFF_LAST) begin
                        state_d    = ST_ON;
                        amp_d      = 1'b1;
                        cnt_tono_d = '0;
                        cnt_fase_d = '0;
                    end else begin
                        cnt_fase_d = cnt_fase_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    amp_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    amp_d   = 1'b0;
                end
            endcase
        end
    end

    assign bus.ampPWM  = amp_q;
    assign bus.estado  = state_q;
    assign bus.sonando = (state_q == ST_ON) || (state_q == ST_OFF);

endmodule
